// File: rtl/fea_pro.sv
// -----------------------------------------------------------------------------
// fea_pro : stereo feature extractor and matcher
//
// Receives a left image and then a right image as raster-ordered 8-bit pixels.
// Each interior pixel whose 3x3 neighbourhood shows enough contrast becomes a
// feature. Its position and an 8-bit census descriptor go into a per-image
// table. After the right image, each left feature is compared with every right
// feature on the same row at or left of it. The closest descriptor, if close
// enough, is reported as a match record.
//
// Ports
//   clk            in   1   rising-edge clock
//   rst            in   1   asynchronous active-high reset
//   img_din        in   8   pixel value, raster order
//   img_din_valid  in   1   qualifies img_din, one pixel per high cycle
//   dout_valid     out  1   one-cycle match strobe
//   dout_data      out  64  {4'b0, Rx, Ry, Px, Py, Lx, Ly}, 10 bits each;
//                           holds its value between strobes
//   done           out  1   one-cycle pulse when a left/right pair is finished
// -----------------------------------------------------------------------------
module fea_pro #(
  parameter int Img_Height = 100,
  parameter int Img_Width  = 120,
  parameter int Max_Feat   = 16,
  parameter int Thresh     = 20,
  parameter int Max_Hd     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  img_din,
  input  logic        img_din_valid,
  output logic        dout_valid,
  output logic [63:0] dout_data,
  output logic        done
);

  localparam int CW  = 10;                      // coordinate width in records
  localparam int XIW = $clog2(Img_Width);       // line-buffer index width
  localparam int FW  = $clog2(Max_Feat + 1);    // feature count width
  localparam int FIW = $clog2(Max_Feat);        // feature table index width

  typedef enum logic [1:0] {CAP_L, CAP_R, MATCH, DONE} state_t;
  typedef enum logic [1:0] {M_SETUP, M_SCAN, M_EMIT} mphase_t;

  function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    logic signed [8:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? 8'(-d) : 8'(d);
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int k = 0; k < 8; k++) s = s + {3'd0, v[k]};
    return s;
  endfunction

  state_t  state;
  mphase_t mphase;

  logic [CW-1:0] x_cnt, y_cnt;
  logic [7:0]    win [3][3];      // [row][col]; row 0 = line y-2, col 2 = newest column
  logic [7:0]    lb1 [Img_Width]; // line y-1
  logic [7:0]    lb2 [Img_Width]; // line y-2
  logic [7:0]    lb1_rd, lb2_rd;
  logic [XIW-1:0] xi;

  logic          capture;
  logic [7:0]    nb [8];          // NW,N,NE,W,E,SW,S,SE at indices 7..0
  logic [7:0]    ctr;
  logic [7:0]    over;
  logic [7:0]    census;
  logic          interior;
  logic          feat_p0;

  logic          vld_p1;
  logic          sel_p1;          // 1: feature belongs to the right image
  logic [CW-1:0] fx_p1, fy_p1;
  logic [7:0]    desc_p1;

  logic [CW-1:0] lt_x [Max_Feat];
  logic [CW-1:0] lt_y [Max_Feat];
  logic [7:0]    lt_d [Max_Feat];
  logic [CW-1:0] rt_x [Max_Feat];
  logic [CW-1:0] rt_y [Max_Feat];
  logic [7:0]    rt_d [Max_Feat];
  logic [FW-1:0] nl, nr;
  logic          lt_wr, rt_wr;

  logic [FW-1:0] i_idx, j_idx;
  logic [CW-1:0] l_x, l_y, r_x, r_y;
  logic [7:0]    l_d, r_d;
  logic [3:0]    hd;
  logic          scan_act, cand, take;
  logic          best_vld;
  logic [3:0]    best_hd;
  logic [CW-1:0] best_rx, best_ry;
  logic [CW-1:0] px, py;

  assign capture = img_din_valid && ((state == CAP_L) || (state == CAP_R));
  assign xi      = x_cnt[XIW-1:0];
  assign lb1_rd  = lb1[xi];
  assign lb2_rd  = lb2[xi];

  // Stage p0: neighbourhood of (x-1, y-1) while pixel (x, y) arrives
  always_comb begin
    nb[7] = win[0][1];
    nb[6] = win[0][2];
    nb[5] = lb2_rd;
    nb[4] = win[1][1];
    nb[3] = lb1_rd;
    nb[2] = win[2][1];
    nb[1] = win[2][2];
    nb[0] = img_din;
    ctr   = win[1][2];
    over   = 8'd0;
    census = 8'd0;
    for (int k = 0; k < 8; k++) begin
      over[k]   = abs_diff(ctr, nb[k]) > 8'(Thresh);
      census[k] = ctr > nb[k];
    end
    // The centre is at most (W-2, H-2) by construction, so only the top and
    // left borders need excluding; that also keeps stale window columns and
    // line-buffer rows from a previous line or image out of use.
    interior = (x_cnt >= CW'(2)) && (y_cnt >= CW'(2));
    feat_p0  = capture && interior && (popcount8(over) >= 4'd6);
  end

  assign lt_wr = vld_p1 && !sel_p1 && (nl < FW'(Max_Feat));
  assign rt_wr = vld_p1 &&  sel_p1 && (nr < FW'(Max_Feat));

  assign l_x = lt_x[i_idx[FIW-1:0]];
  assign l_y = lt_y[i_idx[FIW-1:0]];
  assign l_d = lt_d[i_idx[FIW-1:0]];
  assign r_x = rt_x[j_idx[FIW-1:0]];
  assign r_y = rt_y[j_idx[FIW-1:0]];
  assign r_d = rt_d[j_idx[FIW-1:0]];

  // Strict less-than keeps the earliest j on equal distances.
  assign hd       = popcount8(l_d ^ r_d);
  assign scan_act = (state == MATCH) && (mphase == M_SCAN) && (j_idx < nr);
  assign cand     = (r_y == l_y) && (r_x <= l_x);
  assign take     = scan_act && cand && (!best_vld || (hd < best_hd));
  assign px       = l_x - best_rx;
  assign py       = l_y - best_ry;

  // Storage without reset: line buffers, stage p1 payload, tables, best candidate
  always_ff @(posedge clk) begin
    if (capture) begin
      lb2[xi] <= lb1_rd;
      lb1[xi] <= img_din;
      fx_p1   <= x_cnt - 1'b1;
      fy_p1   <= y_cnt - 1'b1;
      desc_p1 <= census;
    end
    // Stage p1: table write of the feature detected one cycle earlier
    if (lt_wr) begin
      lt_x[nl[FIW-1:0]] <= fx_p1;
      lt_y[nl[FIW-1:0]] <= fy_p1;
      lt_d[nl[FIW-1:0]] <= desc_p1;
    end
    if (rt_wr) begin
      rt_x[nr[FIW-1:0]] <= fx_p1;
      rt_y[nr[FIW-1:0]] <= fy_p1;
      rt_d[nr[FIW-1:0]] <= desc_p1;
    end
    if (take) begin
      best_hd <= hd;
      best_rx <= r_x;
      best_ry <= r_y;
    end
  end

  // Control, window and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= CAP_L;
      mphase     <= M_SETUP;
      x_cnt      <= '0;
      y_cnt      <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= 8'd0;
      vld_p1     <= 1'b0;
      sel_p1     <= 1'b0;
      nl         <= '0;
      nr         <= '0;
      i_idx      <= '0;
      j_idx      <= '0;
      best_vld   <= 1'b0;
      dout_valid <= 1'b0;
      dout_data  <= 64'd0;
      done       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      done       <= 1'b0;
      vld_p1     <= feat_p0;
      if (lt_wr) nl <= nl + 1'b1;
      if (rt_wr) nr <= nr + 1'b1;

      if (capture) begin
        sel_p1 <= (state == CAP_R);
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb2_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= img_din;
        if (x_cnt == CW'(Img_Width - 1)) begin
          x_cnt <= '0;
          if (y_cnt == CW'(Img_Height - 1)) begin
            y_cnt  <= '0;
            mphase <= M_SETUP;
            state  <= (state == CAP_L) ? CAP_R : MATCH;
          end else begin
            y_cnt <= y_cnt + 1'b1;
          end
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end

      case (state)
        MATCH: begin
          case (mphase)
            // One spare cycle lets the last right-image feature land in its table.
            M_SETUP: begin
              i_idx    <= '0;
              j_idx    <= '0;
              best_vld <= 1'b0;
              if (nl == '0) state <= DONE;
              else          mphase <= M_SCAN;
            end
            M_SCAN: begin
              if (take) best_vld <= 1'b1;
              if ((j_idx + 1'b1) >= nr) mphase <= M_EMIT;
              else                      j_idx  <= j_idx + 1'b1;
            end
            default: begin
              if (best_vld && (best_hd <= 4'(Max_Hd))) begin
                dout_valid <= 1'b1;
                dout_data  <= {4'd0, best_rx, best_ry, px, py, l_x, l_y};
              end
              best_vld <= 1'b0;
              j_idx    <= '0;
              if ((i_idx + 1'b1) >= nl) begin
                state <= DONE;
              end else begin
                i_idx  <= i_idx + 1'b1;
                mphase <= M_SCAN;
              end
            end
          endcase
        end
        DONE: begin
          done  <= 1'b1;
          nl    <= '0;
          nr    <= '0;
          state <= CAP_L;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fea_pro.sv
module tb_fea_pro;

  localparam int H = 48;
  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  img_din;
  logic        img_din_valid;
  logic        dout_valid;
  logic [63:0] dout_data;
  logic        done;

  fea_pro #(
    .Img_Height(H),
    .Img_Width (W),
    .Max_Feat  (16),
    .Thresh    (20),
    .Max_Hd    (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .img_din      (img_din),
    .img_din_valid(img_din_valid),
    .dout_valid   (dout_valid),
    .dout_data    (dout_data),
    .done         (done)
  );

  always #5 clk = ~clk;

  logic [63:0] rec_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (dout_valid) rec_q.push_back(dout_data);
    if (done) done_cnt++;
  end

  int n_asrt = 0;
  int n_fail = 0;

  int lpx[32], lpy[32], nlp;
  int rpx[32], rpy[32], nrp;
  int bg;
  bit gap_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_rec(input int rx, input int ry, input int lx, input int ly);
    logic [9:0] a, b, c, d, e, f;
    a = 10'(rx); b = 10'(ry); c = 10'(lx - rx); d = 10'(ly - ry); e = 10'(lx); f = 10'(ly);
    return {4'd0, a, b, c, d, e, f};
  endfunction

  function automatic logic [7:0] pix(input int x, input int y, input bit right);
    int n;
    n = right ? nrp : nlp;
    for (int k = 0; k < n; k++) begin
      if (!right && lpx[k] == x && lpy[k] == y) return 8'd200;
      if ( right && rpx[k] == x && rpy[k] == y) return 8'd200;
    end
    return 8'(bg);
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    img_din_valid = v;
    img_din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_image(input bit right);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (gap_en && $urandom_range(0, 2) == 0) drive(1'b0, 8'($urandom_range(0, 255)));
        drive(1'b1, pix(x, y, right));
      end
  endtask

  // Runs one left/right pair; junk valid pixels are fed for the first `junk`
  // cycles after the right image. Returns the cycles until done was seen.
  task automatic run_pair(input string tag, input int junk, output int wait_cyc);
    int base, k;
    base = done_cnt;
    send_image(1'b0);
    send_image(1'b1);
    k = 0;
    while (done_cnt == base && k < 2000) begin
      if (k < junk) drive(1'b1, 8'($urandom_range(0, 255)));
      else          drive(1'b0, 8'h00);
      k++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != base), 64'd1);
    for (int c = 0; c < 5; c++) drive(1'b0, 8'h00);
    chk({tag, "_done_once"}, 64'(done_cnt - base), 64'd1);
    wait_cyc = k;
  endtask

  initial begin
    int b, wc;
    logic [63:0] r037;
    r037 = mk_rec(45, 40, 50, 40);

    rst = 1'b1;
    img_din = 8'h00;
    img_din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_dout_data", dout_data, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    drive(1'b0, 8'h00);

    // Flat images
    bg = 128; nlp = 0; nrp = 0;
    b = rec_q.size();
    run_pair("flat", 0, wc);
    chk("flat_nmatch", 64'(rec_q.size() - b), 64'd0);

    // Single point, shifted five columns left in the right image
    bg = 100; nlp = 1; lpx[0] = 50; lpy[0] = 40;
    nrp = 1; rpx[0] = 45; rpy[0] = 40;
    b = rec_q.size();
    run_pair("pt", 0, wc);
    chk("pt_nmatch", 64'(rec_q.size() - b), 64'd1);
    if (rec_q.size() > b) chk("pt_rec", rec_q[b], r037);
    chk("pt_hold_data", dout_data, r037);
    chk("pt_hold_valid", 64'(dout_valid), 64'd0);

    // Different row: not a candidate
    rpx[0] = 45; rpy[0] = 41;
    b = rec_q.size();
    run_pair("row", 0, wc);
    chk("row_nmatch", 64'(rec_q.size() - b), 64'd0);
    chk("row_hold_data", dout_data, r037);

    // Right of the left point: not a candidate
    rpx[0] = 55; rpy[0] = 40;
    b = rec_q.size();
    run_pair("col", 0, wc);
    chk("col_nmatch", 64'(rec_q.size() - b), 64'd0);

    // Twenty points on distinct rows; only the first sixteen fit the tables.
    // Pixels fed during MATCH must be ignored.
    nlp = 20; nrp = 20;
    for (int k = 0; k < 20; k++) begin
      lpx[k] = 5 + 2 * k; lpy[k] = 2 + 2 * k;
      rpx[k] = 2 + 2 * k; rpy[k] = 2 + 2 * k;
    end
    b = rec_q.size();
    run_pair("many", 100, wc);
    chk("many_nmatch", 64'(rec_q.size() - b), 64'd16);
    chk("many_match_len", 64'(wc <= 16 * 18 + 4 + 2), 64'd1);
    for (int k = 0; k < 16; k++)
      if (rec_q.size() > b + k)
        chk($sformatf("many_rec%0d", k), rec_q[b + k], mk_rec(2 + 2 * k, 2 + 2 * k, 5 + 2 * k, 2 + 2 * k));

    // Single point pair with random input gaps
    nlp = 1; lpx[0] = 50; lpy[0] = 40;
    nrp = 1; rpx[0] = 45; rpy[0] = 40;
    gap_en = 1'b1;
    b = rec_q.size();
    run_pair("gap", 0, wc);
    gap_en = 1'b0;
    chk("gap_nmatch", 64'(rec_q.size() - b), 64'd1);
    if (rec_q.size() > b) chk("gap_rec", rec_q[b], r037);

    // Reset partway through a noisy left image, then a clean pair
    for (int k = 0; k < 1000; k++) drive(1'b1, 8'($urandom_range(0, 255)));
    rst = 1'b1;
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);
    chk("mid_rst_data", dout_data, 64'd0);
    chk("mid_rst_valid", 64'(dout_valid), 64'd0);
    rst = 1'b0;
    drive(1'b0, 8'h00);
    b = rec_q.size();
    run_pair("rst", 0, wc);
    chk("rst_nmatch", 64'(rec_q.size() - b), 64'd1);
    if (rec_q.size() > b) chk("rst_rec", rec_q[b], r037);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
